// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 4-digit BCD scanner with dead time, decimal points and leading-zero blanking
module display_scanner #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_sel,
  output logic        dp_out
);
  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] snap;
  logic [3:0]  snap_dp;
  logic [3:0]  blank;
  logic        last;
  logic        show;
  assign last = cnt == 16'(CLK_DIV - 1);
  // leading-zero suppression: a digit is blank only if it and every higher digit are zero
  always_comb begin
    blank[3] = blank_lz && snap[15:12] == 4'd0;
    blank[2] = blank[3] && snap[11:8] == 4'd0;
    blank[1] = blank[2] && snap[7:4] == 4'd0;
    blank[0] = 1'b0;
    show     = ena && cnt >= 16'(BLANK_CYCLES) && !blank[idx];
  end
  // prescaler, slot index and frame-coherent snapshot; ena low tracks inputs and parks at slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      snap    <= '0;
      snap_dp <= '0;
    end else if (!ena) begin
      cnt     <= '0;
      idx     <= '0;
      snap    <= digits_in;
      snap_dp <= dp_mask;
    end else begin
      cnt <= last ? '0 : cnt + 16'd1;
      idx <= last ? idx + 2'd1 : idx;
      if (last && idx == 2'd3) begin
        snap    <= digits_in;
        snap_dp <= dp_mask;
      end
    end
  end
  // registered outputs: code held for the whole slot, enable only after the dead time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out   <= 4'hF;
      digit_sel <= '0;
      dp_out    <= 1'b0;
    end else begin
      bcd_out   <= (ena && !blank[idx]) ? snap[4*idx +: 4] : 4'hF;
      digit_sel <= show ? 4'b0001 << idx : 4'b0000;
      dp_out    <= show && snap_dp[idx];
    end
  end
endmodule
